// File: rtl/stream_monitor_pkg.sv
// Shared widths, pipeline stage record and saturating arithmetic for the stream error monitor.
package stream_monitor_pkg;

    // Widest sample supported; stage fields are sized for it and sliced down by the user.
    localparam int unsigned MaxDw = 32;

    function automatic int unsigned err_w(input int unsigned dw);
        return dw + 1;
    endfunction

    function automatic int unsigned err_sq_w(input int unsigned dw);
        return 2 * (dw + 1);
    endfunction

    function automatic int unsigned ref_sq_w(input int unsigned dw);
        return 2 * dw;
    endfunction

    typedef struct packed {
        logic             valid;
        logic [MaxDw:0]   err;
        logic [MaxDw-1:0] ref_val;
    } stage_t;

    // Returns {saturated, sum} with sum clamped to 2^w-1 (w <= 64).
    function automatic logic [64:0] sat_add(input logic [63:0] acc, input logic [63:0] inc,
                                            input int unsigned w);
        logic [64:0] lim;
        logic [64:0] sum;
        lim = (65'd1 << w) - 65'd1;
        sum = {1'b0, acc} + {1'b0, inc};
        if (sum > lim) begin
            return {1'b1, lim[63:0]};
        end
        return {1'b0, sum[63:0]};
    endfunction

endpackage

// File: rtl/ref_align_fifo.sv
// Reference alignment FIFO: holds reference samples until the matching filter output arrives.
module ref_align_fifo #(
    parameter int unsigned DW         = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic          clk_i,
    input  logic          srst_n_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic          pop_valid_o,
    output logic [DW-1:0] pop_data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop, bypass, do_push, do_pop;

    assign push    = push_i & ~flush_i;
    assign pop     = pop_i & ~flush_i;
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    // A same-cycle push and pop on an empty FIFO pairs directly without touching storage.
    assign bypass  = empty_o & push & pop;
    assign do_pop  = pop & ~empty_o;
    assign do_push = push & ~bypass & (~full_o | do_pop);

    assign overflow_o  = push & full_o & ~pop;
    assign underflow_o = pop & empty_o & ~push;
    assign pop_valid_o = do_pop | bypass;
    assign pop_data_o  = bypass ? push_data_i : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/stream_error_monitor.sv
// Pairs filter outputs with buffered references and accumulates error/energy/peak statistics.
module stream_error_monitor
    import stream_monitor_pkg::*;
#(
    parameter int unsigned DW         = 16,
    parameter int unsigned ACC_W      = 48,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             srst_n_i,
    input  logic             clear_i,
    input  logic             ref_valid_i,
    input  logic [DW-1:0]    ref_data_i,
    input  logic             dut_valid_i,
    input  logic [DW-1:0]    dut_data_i,
    output logic [ACC_W-1:0] err2_acc_o,
    output logic [ACC_W-1:0] ref2_acc_o,
    output logic [DW:0]      peak_err_o,
    output logic [CNT_W-1:0] count_o,
    output logic             stats_valid_o,
    output logic             fifo_overflow_o,
    output logic             fifo_underflow_o,
    output logic             acc_sat_o
);

    localparam int unsigned EW  = err_w(DW);
    localparam int unsigned E2W = err_sq_w(DW);
    localparam int unsigned R2W = ref_sq_w(DW);

    logic          pair_valid, ovf_evt, udf_evt;
    logic [DW-1:0] pair_ref;

    ref_align_fifo #(
        .DW        (DW),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .srst_n_i   (srst_n_i),
        .flush_i    (clear_i),
        .push_i     (ref_valid_i),
        .push_data_i(ref_data_i),
        .pop_i      (dut_valid_i),
        .pop_valid_o(pair_valid),
        .pop_data_o (pair_ref),
        .empty_o    (),
        .full_o     (),
        .overflow_o (ovf_evt),
        .underflow_o(udf_evt)
    );

    logic             pv_q, pv_d;
    logic [DW-1:0]    pref_q, pref_d, pdut_q, pdut_d;
    stage_t           s1_q, s1_d;
    logic             s2_valid_q, s2_valid_d;
    logic [E2W-1:0]   s2_e2_q, s2_e2_d;
    logic [R2W-1:0]   s2_r2_q, s2_r2_d;
    logic [EW-1:0]    s2_abs_q, s2_abs_d;
    logic [ACC_W-1:0] err2_q, err2_d, ref2_q, ref2_d;
    logic [EW-1:0]    peak_q, peak_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stats_q, stats_d, ovf_q, ovf_d, udf_q, udf_d, sat_q, sat_d;

    logic [EW-1:0]  e_s1, e_s2;
    logic [E2W-1:0] e_ext;
    logic [R2W-1:0] r_ext;
    logic [DW-1:0]  r_s2;
    logic [64:0]    err_sum, ref_sum;

    assign e_s1 = $signed({pref_q[DW-1], pref_q}) - $signed({pdut_q[DW-1], pdut_q});
    assign e_s2 = s1_q.err[EW-1:0];
    assign r_s2 = s1_q.ref_val[DW-1:0];
    // Sign-extended operands make the modular unsigned product equal the true square.
    assign e_ext = {{(E2W-EW){e_s2[EW-1]}}, e_s2};
    assign r_ext = {{(R2W-DW){r_s2[DW-1]}}, r_s2};

    assign err_sum = sat_add(64'(err2_q), 64'(s2_e2_q), ACC_W);
    assign ref_sum = sat_add(64'(ref2_q), 64'(s2_r2_q), ACC_W);

    always_comb begin
        pv_d       = pair_valid;
        pref_d     = pair_ref;
        pdut_d     = dut_data_i;
        s1_d.valid   = pv_q;
        s1_d.err     = {{(MaxDw+1-EW){e_s1[EW-1]}}, e_s1};
        s1_d.ref_val = {{(MaxDw-DW){pref_q[DW-1]}}, pref_q};
        s2_valid_d = s1_q.valid;
        s2_e2_d    = e_ext * e_ext;
        s2_r2_d    = r_ext * r_ext;
        s2_abs_d   = e_s2[EW-1] ? (~e_s2 + EW'(1)) : e_s2;
        err2_d     = err2_q;
        ref2_d     = ref2_q;
        peak_d     = peak_q;
        count_d    = count_q;
        stats_d    = 1'b0;
        ovf_d      = ovf_q | ovf_evt;
        udf_d      = udf_q | udf_evt;
        sat_d      = sat_q;
        if (s2_valid_q) begin
            err2_d  = err_sum[ACC_W-1:0];
            ref2_d  = ref_sum[ACC_W-1:0];
            sat_d   = sat_q | err_sum[64] | ref_sum[64];
            count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
            peak_d  = (s2_abs_q > peak_q) ? s2_abs_q : peak_q;
            stats_d = 1'b1;
        end
        if (clear_i) begin
            pv_d       = 1'b0;
            s1_d       = '0;
            s2_valid_d = 1'b0;
            err2_d     = '0;
            ref2_d     = '0;
            peak_d     = '0;
            count_d    = '0;
            stats_d    = 1'b0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
            sat_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            pv_q       <= 1'b0;
            pref_q     <= '0;
            pdut_q     <= '0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_e2_q    <= '0;
            s2_r2_q    <= '0;
            s2_abs_q   <= '0;
            err2_q     <= '0;
            ref2_q     <= '0;
            peak_q     <= '0;
            count_q    <= '0;
            stats_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            pv_q       <= pv_d;
            pref_q     <= pref_d;
            pdut_q     <= pdut_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_e2_q    <= s2_e2_d;
            s2_r2_q    <= s2_r2_d;
            s2_abs_q   <= s2_abs_d;
            err2_q     <= err2_d;
            ref2_q     <= ref2_d;
            peak_q     <= peak_d;
            count_q    <= count_d;
            stats_q    <= stats_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            sat_q      <= sat_d;
        end
    end

    assign err2_acc_o       = err2_q;
    assign ref2_acc_o       = ref2_q;
    assign peak_err_o       = peak_q;
    assign count_o          = count_q;
    assign stats_valid_o    = stats_q;
    assign fifo_overflow_o  = ovf_q;
    assign fifo_underflow_o = udf_q;
    assign acc_sat_o        = sat_q;

endmodule

// File: tb/tb_stream_error_monitor.sv
// Self-checking bench: vector table, corner sequences and randomized traffic against a queue model.
module tb_stream_error_monitor;

    localparam int DEPTH = 16;
    localparam int ACC_W = 48;

    logic        clk = 1'b0;
    logic        srst_n, clear, rv, dv;
    logic [15:0] rd, dd;

    logic [47:0] err2, ref2;
    logic [16:0] peak;
    logic [31:0] cnt;
    logic        stats, ovf, udf, sat;

    logic [32:0] s_err2, s_ref2;
    logic [16:0] s_peak;
    logic [31:0] s_cnt;
    logic        s_stats, s_ovf, s_udf, s_sat;

    stream_error_monitor #(.DW(16), .ACC_W(48), .CNT_W(32), .FIFO_DEPTH(16)) u_dut (
        .clk_i(clk), .srst_n_i(srst_n), .clear_i(clear),
        .ref_valid_i(rv), .ref_data_i(rd), .dut_valid_i(dv), .dut_data_i(dd),
        .err2_acc_o(err2), .ref2_acc_o(ref2), .peak_err_o(peak), .count_o(cnt),
        .stats_valid_o(stats), .fifo_overflow_o(ovf), .fifo_underflow_o(udf), .acc_sat_o(sat)
    );

    stream_error_monitor #(.DW(16), .ACC_W(33), .CNT_W(32), .FIFO_DEPTH(16)) u_dut_sat (
        .clk_i(clk), .srst_n_i(srst_n), .clear_i(clear),
        .ref_valid_i(rv), .ref_data_i(rd), .dut_valid_i(dv), .dut_data_i(dd),
        .err2_acc_o(s_err2), .ref2_acc_o(s_ref2), .peak_err_o(s_peak), .count_o(s_cnt),
        .stats_valid_o(s_stats), .fifo_overflow_o(s_ovf), .fifo_underflow_o(s_udf),
        .acc_sat_o(s_sat)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a queue of pending references plus a list of pairs awaiting retirement.
    typedef struct { int due; longint e; longint r; } pend_t;
    int              q[$];
    pend_t           pend[$];
    int              cyc = 0;
    longint unsigned m_err2, m_ref2, m_peak, m_cnt;
    bit              m_stats, m_ovf, m_udf, m_sat;

    task automatic model_edge(input bit r_n, input bit clr, input bit v_r, input int d_r,
                              input bit v_d, input int d_d);
        longint unsigned lim;
        longint          e;
        pend_t           p;
        lim = (64'd1 << ACC_W) - 1;
        cyc++;
        m_stats = 0;
        if (!r_n || clr) begin
            m_err2 = 0; m_ref2 = 0; m_peak = 0; m_cnt = 0;
            m_ovf = 0; m_udf = 0; m_sat = 0;
            q.delete();
            pend.delete();
            return;
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            p = pend.pop_front();
            if (m_err2 + longint'(p.e * p.e) > lim) begin m_err2 = lim; m_sat = 1; end
            else m_err2 = m_err2 + longint'(p.e * p.e);
            if (m_ref2 + longint'(p.r * p.r) > lim) begin m_ref2 = lim; m_sat = 1; end
            else m_ref2 = m_ref2 + longint'(p.r * p.r);
            e = (p.e < 0) ? -p.e : p.e;
            if (e > longint'(m_peak)) m_peak = e;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            m_stats = 1;
        end
        if (v_d) begin
            if (q.size() > 0) begin
                p.r = q.pop_front();
                p.e = p.r - d_d;
                p.due = cyc + 3;
                pend.push_back(p);
                if (v_r) q.push_back(d_r);
            end else if (v_r) begin
                p.r = d_r; p.e = d_r - d_d; p.due = cyc + 3;
                pend.push_back(p);
            end else begin
                m_udf = 1;
            end
        end else if (v_r) begin
            if (q.size() == DEPTH) m_ovf = 1;
            else q.push_back(d_r);
        end
    endtask

    task automatic check_model();
        chk("err2", err2, m_err2);
        chk("ref2", ref2, m_ref2);
        chk("peak", peak, m_peak);
        chk("count", cnt, m_cnt);
        chk("stats_valid", stats, m_stats);
        chk("overflow", ovf, m_ovf);
        chk("underflow", udf, m_udf);
        chk("acc_sat", sat, m_sat);
    endtask

    task automatic cycle(input bit r_n, input bit clr, input bit v_r, input int d_r,
                         input bit v_d, input int d_d);
        srst_n = r_n; clear = clr; rv = v_r; rd = 16'(d_r); dv = v_d; dd = 16'(d_d);
        @(posedge clk);
        model_edge(r_n, clr, v_r, d_r, v_d, d_d);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit r_n; bit clr; bit v_r; int d_r; bit v_d; int d_d;
        longint unsigned x_err2; longint unsigned x_ref2; int x_peak; int x_cnt; bit x_stats;
    } vec_t;
    vec_t tbl[11];

    initial begin
        // Reset with strobes toggling, then identity stream with a 2-cycle filter delay.
        tbl[0]  = '{0, 0, 1,    7, 1,    3,      0,      0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1,    9, 0,    0,      0,      0, 0, 0, 0};
        tbl[2]  = '{1, 0, 1,  100, 0,    0,      0,      0, 0, 0, 0};
        tbl[3]  = '{1, 0, 1,  200, 0,    0,      0,      0, 0, 0, 0};
        tbl[4]  = '{1, 0, 1, -300, 1,  100,      0,      0, 0, 0, 0};
        tbl[5]  = '{1, 0, 0,    0, 1,  200,      0,      0, 0, 0, 0};
        tbl[6]  = '{1, 0, 0,    0, 1, -300,      0,      0, 0, 0, 0};
        tbl[7]  = '{1, 0, 0,    0, 0,    0,      0,  10000, 0, 1, 1};
        tbl[8]  = '{1, 0, 0,    0, 0,    0,      0,  50000, 0, 2, 1};
        tbl[9]  = '{1, 0, 0,    0, 0,    0,      0, 140000, 0, 3, 1};
        tbl[10] = '{1, 0, 0,    0, 0,    0,      0, 140000, 0, 3, 0};

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].r_n, tbl[i].clr, tbl[i].v_r, tbl[i].d_r, tbl[i].v_d, tbl[i].d_d);
            chk("tbl_err2", err2, tbl[i].x_err2);
            chk("tbl_ref2", ref2, tbl[i].x_ref2);
            chk("tbl_peak", peak, longint'(tbl[i].x_peak));
            chk("tbl_count", cnt, longint'(tbl[i].x_cnt));
            chk("tbl_stats", stats, tbl[i].x_stats);
        end

        // Error magnitude, including the extreme e = -65535.
        cycle(1, 0, 1, 1000, 0, 0);
        cycle(1, 0, 0, 0, 1, 990);
        idle(3);
        chk("mag_err2", err2, 100);
        chk("mag_peak", peak, 10);
        cycle(1, 0, 1, -32768, 0, 0);
        cycle(1, 0, 0, 0, 1, 32767);
        idle(3);
        chk("mag_err2_max", err2, 64'd4294836325);
        chk("mag_peak_max", peak, 65535);

        // Bypass on an empty FIFO.
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 0, 1, 5, 1, 3);
        idle(3);
        chk("byp_err2", err2, 4);
        chk("byp_ref2", ref2, 25);
        chk("byp_count", cnt, 1);
        chk("byp_flags", {ovf, udf, sat}, 0);

        // Overflow, drain, then underflow.
        cycle(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) cycle(1, 0, 1, i * 3 - 20, 0, 0);
        chk("ovf_flag", ovf, 1);
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0, 1, i);
        idle(3);
        chk("drain_count", cnt, 16);
        chk("drain_udf", udf, 0);
        cycle(1, 0, 0, 0, 1, 0);
        idle(3);
        chk("udf_flag", udf, 1);
        chk("udf_count", cnt, 16);
        chk("ovf_sticky", ovf, 1);

        // Saturation on the 33-bit instance, then clear.
        cycle(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 1, -32768, 1, 32767);
            idle(3);
            if (i == 1) begin
                chk("sat_err2_2", s_err2, 64'd8589672450);
                chk("sat_flag_2", s_sat, 0);
            end
        end
        chk("sat_err2_3", s_err2, 64'd8589934591);
        chk("sat_flag_3", s_sat, 1);
        cycle(1, 1, 1, 11, 1, 12);
        chk("clr_sat_outs", {s_err2, s_ref2, s_peak, s_cnt}, 0);
        chk("clr_sat_flags", {s_stats, s_ovf, s_udf, s_sat}, 0);

        // Randomized traffic with shifting strobe densities, occasional clear and reset.
        for (int i = 0; i < 3000; i++) begin
            int ph, pr, pd;
            ph = (i / 300) % 3;
            pr = (ph == 0) ? 50 : (ph == 1) ? 75 : 30;
            pd = (ph == 0) ? 50 : (ph == 1) ? 30 : 75;
            cycle(($urandom % 200) != 0, ($urandom % 90) == 0,
                  ($urandom % 100) < pr, int'($urandom_range(0, 65535)) - 32768,
                  ($urandom % 100) < pd, int'($urandom_range(0, 65535)) - 32768);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
